ddr_burst_arbiter: RTL
======================

Name: ddr_burst_arbiter

Overview:
- Sits directly downstream of the AP data cache (and beside the instruction cache) and owns the single DDR burst port.
- Arbitrates data-store, data-load, jump-address and instruction-fetch requests, and drives the burst read/write handshakes.
- Returns read beats with a running beat count, and exposes its state code so the data cache can pace its store stream.

Parameters:
DATA_WIDTH, 16, AP data word width
DDR_ADDR_WIDTH, 28, DDR address width
MEM_DATA_BITS, 64, DDR burst data width
DATA_BURST_LEN, 16, beats per data load/store burst (equals data cache depth)
INSTR_BURST_LEN, 16, beats per instruction fetch burst
INSTR_WIDTH, 16, instruction word width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
DATA_read_req  in  1  data cache load request (level)
DATA_store_req  in  1  data cache store request (level)
JMP_ADDR_read_req  in  1  jump-address fetch request (level)
INSTR_read_req  in  1  instruction cache fill request (level)
DATA_read_addr  in  DDR_ADDR_WIDTH  load / jump-fetch address
DATA_write_addr  in  DDR_ADDR_WIDTH  store address
INSTR_read_addr  in  DDR_ADDR_WIDTH  fill address
DATA_to_ddr  in  DATA_WIDTH  store word from data cache
data_to_ddr_rdy  in  1  DATA_to_ddr valid
DATA_to_cache  out  DATA_WIDTH  load beat to data cache
JMP_ADDR_to_cache  out  DDR_ADDR_WIDTH  fetched jump address
INSTR_to_cache  out  INSTR_WIDTH  fill beat to instruction cache
rd_cnt_data  out  10  data/jump beats received
rd_cnt_instr  out  10  instruction beats received
rd_burst_data_valid  out  1  registered beat strobe to caches
wr_burst_data_req  out  1  store beat request to data cache
state_interface_module  out  4  current state code
rd_burst_req  out  1  DDR read request
rd_burst_len  out  10  DDR read length
rd_burst_addr  out  DDR_ADDR_WIDTH  DDR read address
rd_burst_data_valid_ddr  in  1  DDR read beat valid
rd_burst_data  in  MEM_DATA_BITS  DDR read beat
rd_burst_finish  in  1  DDR read done (1-cycle pulse)
wr_burst_req  out  1  DDR write request
wr_burst_len  out  10  DDR write length
wr_burst_addr  out  DDR_ADDR_WIDTH  DDR write address
wr_burst_data_req_ddr  in  1  DDR requests next write beat
wr_burst_data  out  MEM_DATA_BITS  DDR write beat
wr_burst_finish  in  1  DDR write done (1-cycle pulse)

Behaviour:
- Clocking and reset: single clock domain, sync active-high rst.
  - On reset, state is IDLE and every output is 0.
  - Reset mid-burst aborts immediately: requests drop and counters clear.
- State codes:
  - IDLE=0
  - MEM_READ_INSTR=1, MEM_READ_INSTR_END=2
  - MEM_READ_DATA=3, MEM_READ_DATA_END=4
  - MEM_READ_JMP=5, MEM_READ_JMP_END=6
  - MEM_WRITE_DATA_STORE=9, MEM_WRITE_END=10
  - state_interface_module = registered state.
- IDLE arbitration, checked each cycle; fixed priority:
  - DATA_store_req → MEM_WRITE_DATA_STORE.
  - else DATA_read_req → MEM_READ_DATA.
  - else JMP_ADDR_read_req → MEM_READ_JMP.
  - else INSTR_read_req → MEM_READ_INSTR.
  - Addresses and lengths are latched on the transition. Lengths: DATA_BURST_LEN / 1 / INSTR_BURST_LEN.
- Read states:
  - rd_burst_req held high from state entry until the first rd_burst_data_valid_ddr, then low.
  - Each valid beat registers the following, all updating in the same cycle (1-cycle latency):
    - DATA_to_cache = rd_burst_data[DATA_WIDTH-1:0]; INSTR_to_cache likewise.
    - rd_burst_data_valid = 1.
    - The relevant counter increments from 0, so it equals the 1-based beat index of the beat presented.
  - In MEM_READ_JMP, the first beat also latches JMP_ADDR_to_cache = rd_burst_data[DDR_ADDR_WIDTH-1:0].
  - rd_burst_finish moves to the matching _END state. finish in the same cycle as the last valid beat processes the beat first.
- _END states:
  - On entry, the read counter increments once more, to len+1. This signals burst completion to the cache.
  - Stay until the originating request is low, then go to IDLE, clearing both counters.
  - A different request pending at that moment is taken on the following IDLE cycle.
- MEM_WRITE_DATA_STORE:
  - wr_burst_req held until the first wr_burst_data_req_ddr.
  - wr_burst_data_req = wr_burst_data_req_ddr (combinational pass-through, this state only).
  - wr_burst_data = zero-extended DATA_to_ddr when data_to_ddr_rdy, else 0.
  - wr_burst_finish → MEM_WRITE_END; leave when DATA_store_req is low.
- Outside the above, rd_burst_data_valid = 0 and wr_burst_data_req = 0.
- Requests asserted in a non-IDLE state wait; they are never dropped while held.

Test Plan:
- Reset mid data read: rst pulsed at beat 7 → next cycle state 0, rd_burst_req=0, rd_cnt_data=0.
- Data load at addr 0x28000, 16 beats with word k = k+0x100:
  - rd_burst_addr=0x28000, len=16.
  - Beat k presents DATA_to_cache=0x100+k with rd_cnt_data=k+1.
  - After finish, rd_cnt_data=17 until DATA_read_req falls, then 0.
- Store 16 words, DDR asserting wr_burst_data_req_ddr every other cycle:
  - state_interface_module=9 throughout.
  - wr_burst_data beats match DATA_to_ddr.
  - finish → 10, then IDLE after DATA_store_req=0.
- Jump fetch, one beat 0x0000_0000_0123_4560 → JMP_ADDR_to_cache=0x1234560; rd_cnt_data=1 with rd_burst_data_valid=1 on that cycle.
- Simultaneous DATA_store_req, DATA_read_req, INSTR_read_req in IDLE:
  - Served in order store → data read → instruction.
  - Each waits for the previous _END exit; rd_burst_len=16 for the instruction fill.

Source files
------------

// File: rtl/ddr_burst_arbiter_if.sv
// DDR burst port bundle between ddr_burst_arbiter and the DDR controller.
//   master : arbiter side, drives read/write requests, lengths, addresses, write beats
//   slave  : controller side, returns read beats, write-beat requests and finish pulses
interface ddr_burst_arbiter_if #(
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned MEM_DATA_BITS  = 64
);
  logic                      rd_burst_req;
  logic [9:0]                rd_burst_len;
  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr;
  logic                      rd_burst_data_valid_ddr;
  logic [MEM_DATA_BITS-1:0]  rd_burst_data;
  logic                      rd_burst_finish;
  logic                      wr_burst_req;
  logic [9:0]                wr_burst_len;
  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr;
  logic                      wr_burst_data_req_ddr;
  logic [MEM_DATA_BITS-1:0]  wr_burst_data;
  logic                      wr_burst_finish;

  modport master (
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  rd_burst_data_valid_ddr, rd_burst_data, rd_burst_finish,
    input  wr_burst_data_req_ddr, wr_burst_finish
  );

  modport slave (
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output rd_burst_data_valid_ddr, rd_burst_data, rd_burst_finish,
    output wr_burst_data_req_ddr, wr_burst_finish
  );
endinterface

// File: rtl/ddr_burst_arbiter.sv
// Arbiter owning the single DDR burst port, shared by the data cache (load/store),
// jump-address fetch and instruction cache fill. Fixed priority in idle:
// store > data load > jump fetch > instruction fill.
//   clk, rst                 : clock, synchronous active-high reset
//   *_req_i, *_addr_i        : level requests and their addresses
//   DATA_to_ddr_i/_rdy_i     : store word stream from the data cache
//   DATA/INSTR_to_cache_o    : registered read beats; JMP_ADDR_to_cache_o jump target
//   rd_cnt_*_o               : running 1-based beat count, len+1 once the burst is done
//   rd_burst_data_valid_o    : registered beat strobe
//   wr_burst_data_req_o      : store beat request (pass-through of the DDR request)
//   state_interface_module_o : current state code
//   ddr_io                   : DDR burst port
module ddr_burst_arbiter #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned DDR_ADDR_WIDTH  = 28,
  parameter int unsigned MEM_DATA_BITS   = 64,
  parameter int unsigned DATA_BURST_LEN  = 16,
  parameter int unsigned INSTR_BURST_LEN = 16,
  parameter int unsigned INSTR_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      DATA_read_req_i,
  input  logic                      DATA_store_req_i,
  input  logic                      JMP_ADDR_read_req_i,
  input  logic                      INSTR_read_req_i,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr_i,
  input  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr_i,
  input  logic [DDR_ADDR_WIDTH-1:0] INSTR_read_addr_i,
  input  logic [DATA_WIDTH-1:0]     DATA_to_ddr_i,
  input  logic                      data_to_ddr_rdy_i,
  output logic [DATA_WIDTH-1:0]     DATA_to_cache_o,
  output logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache_o,
  output logic [INSTR_WIDTH-1:0]    INSTR_to_cache_o,
  output logic [9:0]                rd_cnt_data_o,
  output logic [9:0]                rd_cnt_instr_o,
  output logic                      rd_burst_data_valid_o,
  output logic                      wr_burst_data_req_o,
  output logic [3:0]                state_interface_module_o,
  ddr_burst_arbiter_if.master       ddr_io
);

  typedef enum logic [3:0] {
    StIdle         = 4'd0,
    StReadInstr    = 4'd1,
    StReadInstrEnd = 4'd2,
    StReadData     = 4'd3,
    StReadDataEnd  = 4'd4,
    StReadJmp      = 4'd5,
    StReadJmpEnd   = 4'd6,
    StWriteStore   = 4'd9,
    StWriteEnd     = 4'd10
  } state_e;

  state_e                    state_q;
  logic                      rd_burst_req_q, wr_burst_req_q;
  logic [9:0]                rd_burst_len_q, wr_burst_len_q;
  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr_q, wr_burst_addr_q;
  logic [DATA_WIDTH-1:0]     data_to_cache_q;
  logic [INSTR_WIDTH-1:0]    instr_to_cache_q;
  logic [DDR_ADDR_WIDTH-1:0] jmp_addr_q;
  logic [9:0]                rd_cnt_data_q, rd_cnt_instr_q;
  logic                      rd_valid_q;
  // Set once the extra len+1 count has been applied in an _END state.
  logic                      end_bump_q;
  logic                      end_req;
  logic                      unused_rd_bits;

  // Request that keeps the current _END state occupied.
  always_comb begin
    end_req = 1'b0;
    case (state_q)
      StReadDataEnd:  end_req = DATA_read_req_i;
      StReadJmpEnd:   end_req = JMP_ADDR_read_req_i;
      StReadInstrEnd: end_req = INSTR_read_req_i;
      default:        end_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      rd_burst_req_q   <= 1'b0;
      wr_burst_req_q   <= 1'b0;
      rd_burst_len_q   <= '0;
      wr_burst_len_q   <= '0;
      rd_burst_addr_q  <= '0;
      wr_burst_addr_q  <= '0;
      data_to_cache_q  <= '0;
      instr_to_cache_q <= '0;
      jmp_addr_q       <= '0;
      rd_cnt_data_q    <= '0;
      rd_cnt_instr_q   <= '0;
      rd_valid_q       <= 1'b0;
      end_bump_q       <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (DATA_store_req_i) begin
            state_q         <= StWriteStore;
            wr_burst_req_q  <= 1'b1;
            wr_burst_addr_q <= DATA_write_addr_i;
            wr_burst_len_q  <= 10'(DATA_BURST_LEN);
          end else if (DATA_read_req_i) begin
            state_q         <= StReadData;
            rd_burst_req_q  <= 1'b1;
            rd_burst_addr_q <= DATA_read_addr_i;
            rd_burst_len_q  <= 10'(DATA_BURST_LEN);
          end else if (JMP_ADDR_read_req_i) begin
            state_q         <= StReadJmp;
            rd_burst_req_q  <= 1'b1;
            rd_burst_addr_q <= DATA_read_addr_i;
            rd_burst_len_q  <= 10'd1;
          end else if (INSTR_read_req_i) begin
            state_q         <= StReadInstr;
            rd_burst_req_q  <= 1'b1;
            rd_burst_addr_q <= INSTR_read_addr_i;
            rd_burst_len_q  <= 10'(INSTR_BURST_LEN);
          end
        end
        StReadData, StReadJmp, StReadInstr: begin
          if (ddr_io.rd_burst_data_valid_ddr) begin
            rd_burst_req_q   <= 1'b0;
            rd_valid_q       <= 1'b1;
            data_to_cache_q  <= ddr_io.rd_burst_data[DATA_WIDTH-1:0];
            instr_to_cache_q <= ddr_io.rd_burst_data[INSTR_WIDTH-1:0];
            if (state_q == StReadInstr) begin
              rd_cnt_instr_q <= rd_cnt_instr_q + 10'd1;
            end else begin
              rd_cnt_data_q <= rd_cnt_data_q + 10'd1;
            end
            if (state_q == StReadJmp && rd_cnt_data_q == 10'd0) begin
              jmp_addr_q <= ddr_io.rd_burst_data[DDR_ADDR_WIDTH-1:0];
            end
          end
          if (ddr_io.rd_burst_finish) begin
            rd_burst_req_q <= 1'b0;
            if (state_q == StReadData) begin
              state_q <= StReadDataEnd;
            end else if (state_q == StReadJmp) begin
              state_q <= StReadJmpEnd;
            end else begin
              state_q <= StReadInstrEnd;
            end
          end
        end
        StReadDataEnd, StReadJmpEnd, StReadInstrEnd: begin
          // Count to len+1 before allowing exit so the cache always sees completion.
          if (!end_bump_q) begin
            end_bump_q <= 1'b1;
            if (state_q == StReadInstrEnd) begin
              rd_cnt_instr_q <= rd_cnt_instr_q + 10'd1;
            end else begin
              rd_cnt_data_q <= rd_cnt_data_q + 10'd1;
            end
          end else if (!end_req) begin
            state_q        <= StIdle;
            end_bump_q     <= 1'b0;
            rd_cnt_data_q  <= '0;
            rd_cnt_instr_q <= '0;
          end
        end
        StWriteStore: begin
          if (ddr_io.wr_burst_data_req_ddr || ddr_io.wr_burst_finish) begin
            wr_burst_req_q <= 1'b0;
          end
          if (ddr_io.wr_burst_finish) begin
            state_q <= StWriteEnd;
          end
        end
        StWriteEnd: begin
          if (!DATA_store_req_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_burst_data_req_o = (state_q == StWriteStore) && ddr_io.wr_burst_data_req_ddr;
  assign ddr_io.wr_burst_data = (state_q == StWriteStore && data_to_ddr_rdy_i) ?
                                MEM_DATA_BITS'(DATA_to_ddr_i) : '0;

  assign ddr_io.rd_burst_req  = rd_burst_req_q;
  assign ddr_io.rd_burst_len  = rd_burst_len_q;
  assign ddr_io.rd_burst_addr = rd_burst_addr_q;
  assign ddr_io.wr_burst_req  = wr_burst_req_q;
  assign ddr_io.wr_burst_len  = wr_burst_len_q;
  assign ddr_io.wr_burst_addr = wr_burst_addr_q;

  assign DATA_to_cache_o          = data_to_cache_q;
  assign INSTR_to_cache_o         = instr_to_cache_q;
  assign JMP_ADDR_to_cache_o      = jmp_addr_q;
  assign rd_cnt_data_o            = rd_cnt_data_q;
  assign rd_cnt_instr_o           = rd_cnt_instr_q;
  assign rd_burst_data_valid_o    = rd_valid_q;
  assign state_interface_module_o = state_q;

  // Upper read-beat bits carry nothing for any consumer.
  assign unused_rd_bits = ^ddr_io.rd_burst_data[MEM_DATA_BITS-1:DDR_ADDR_WIDTH];

endmodule
